reg_dump_reader: RTL
====================

# reg_dump_reader

Debug read-out engine on a dedicated read port of the 32×32 register file: on a start request it walks a contiguous address range, reads each register and streams `{address, data}` words to a debug consumer over a valid/ready handshake. It is the reader counterpart to the register file's write-back port. It sits beside `reg_file`, driven by the debug/trace logic, and never writes the register file.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width (2^ADDR_W registers)

- `clk`  in  1  rising-edge clock
- `areset`  in  1  synchronous, active-low reset
- `start`  in  1  dump request; sampled only in IDLE
- `first_addr`  in  ADDR_W  first register of range; latched with `start`
- `last_addr`  in  ADDR_W  last register of range, inclusive; latched with `start`
- `abort`  in  1  cancel the dump in progress
- `rf_addr`  out  ADDR_W  address to the register file read port (asynchronous read)
- `rf_rdata`  in  DATA_W  register file read data, combinational from `rf_addr`
- `dump_valid`  out  1  output word valid
- `dump_ready`  in  1  consumer accepts the word
- `dump_addr`  out  ADDR_W  register index of the current word
- `dump_data`  out  DATA_W  register contents
- `dump_last`  out  1  current word is `last_addr`
- `busy`  out  1  high in READ, SEND and DONE
- `done`  out  1  one-cycle pulse after the last word is accepted
- `err`  out  1  one-cycle pulse when a request is rejected

## Operation
- FSM states: IDLE, READ, SEND, DONE.
- IDLE:
  - `start`=1 and `first_addr`<=`last_addr`: latch both into `cur` and `last_r`, go to READ.
  - `start`=1 and `first_addr`>`last_addr`: `err`=1 for one cycle, stay in IDLE.
- READ: `rf_addr`=`cur`. At the clock edge, register `rf_rdata`→`dump_data`, `cur`→`dump_addr`, (`cur`==`last_r`)→`dump_last`, set `dump_valid`=1, go to SEND.
- SEND: hold `dump_valid`, `dump_data`, `dump_addr` and `dump_last` stable until `dump_ready`=1.
  - Handshake when `dump_valid`&`dump_ready` are both high at a clock edge.
  - Handshake with `dump_last`=0: `cur`←`cur`+1, `dump_valid`←0, go to READ.
  - Handshake with `dump_last`=1: `dump_valid`←0, `done`←1, go to DONE.
- DONE: `done` is high for this one cycle. Return to IDLE. `start` is ignored here.
- `rf_addr` equals `cur` in every state. In IDLE, `cur` holds its last value.
- `cur` never increments past `last_r`, so there is no wrap. A range of 0..31 ends cleanly at 31.
- `start` in READ, SEND or DONE is ignored, with no `err`.
- `abort`=1 in READ or SEND: next state is IDLE, `dump_valid`←0, no `done`, no `err`. `abort` wins over a simultaneous handshake.
- `abort` in IDLE or DONE has no effect.
- Snapshot coherence is not guaranteed. A write to a register that has not been read yet is visible in the dump. Read data is passed through unmodified, so x0 reads as 0.

## Timing
- Reset (`areset`=0 at a rising edge): state IDLE, and every output 0 (`rf_addr`, `dump_valid`, `dump_addr`, `dump_data`, `dump_last`, `busy`, `done`, `err`). Reset mid-dump discards the dump with no `done`.
- `start` sampled at edge N. READ during cycle N+1. First `dump_valid` from edge N+2.
- Each word costs 2 cycles (READ + SEND) when `dump_ready` is held high. An n-word dump takes 2n cycles from `start` to the last handshake.
- `done` is high in the cycle after the final handshake. IDLE follows, and a new `start` is accepted one cycle after `done`.
- `err` is high in the cycle after the offending `start` edge.
- Back-pressure: each cycle of `dump_ready`=0 in SEND adds one cycle. Outputs do not change while stalled.

## Structure
- Shared package `risc_pkg`: `DATA_W`, `ADDR_W`, and the state encoding typedef (IDLE=0, READ=1, SEND=2, DONE=3), reused by future debug blocks.
- No sub-module. The FSM, the `cur` counter and the output register are inline; the whole block is about 150 lines.

## Test plan
- Reset: hold `areset`=0 for 2 cycles with `start`=1 → all outputs 0 and `busy`=0. Release → IDLE, and `start` then works normally.
- Full dump: preload reg[i]=i*0x11111111 (reg[0]=0), `first`=0, `last`=31, `dump_ready`=1 → 32 words at addr 0..31 with matching data, `dump_last` only on addr 31, `done` 64 cycles after `start`, then `busy`=0.
- Back-pressure: range 3..5, `dump_ready` toggled randomly → exactly 3 words (addr 3,4,5). Data is stable while stalled, with no duplicates and no drops.
- Single word and rejection: `first`=`last`=7 → one word, addr 7, `dump_last`=1, then `done`. Next, `first`=9, `last`=4 → `err` pulse, `busy` stays 0, no `dump_valid`.
- Abort: range 0..31, assert `abort` in SEND at addr 10 together with `dump_ready`=1 → `dump_valid` drops next cycle, no `done`. A new `start` is accepted the cycle after.
- Ignored start: pulse `start` with a different range while busy → the original range completes unchanged and no `err` is raised.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for register-file debug blocks: data/address widths
// and the dump engine state encoding.
package risc_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks a contiguous register range through a read
// port of the register file and streams {address, data} words over valid/ready.
module reg_dump_reader
    import risc_pkg::*;
(
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [DATA_W-1:0] ddata_q, ddata_d;
    logic              dlast_q, dlast_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Next-state and output-register logic; abort takes priority over a handshake.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        valid_d = valid_q;
        daddr_d = daddr_q;
        ddata_d = ddata_q;
        dlast_d = dlast_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (first_addr <= last_addr) begin
                        cur_d   = first_addr;
                        last_d  = last_addr;
                        state_d = ST_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ddata_d = rf_rdata;
                    daddr_d = cur_q;
                    dlast_d = (cur_q == last_q);
                    valid_d = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (dump_ready) begin
                    valid_d = 1'b0;
                    if (dlast_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        // cur only advances below last_q, so it can never wrap
                        cur_d   = cur_q + ADDR_W'(1);
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!areset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            daddr_q <= '0;
            ddata_q <= '0;
            dlast_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            daddr_q <= daddr_d;
            ddata_q <= ddata_d;
            dlast_q <= dlast_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rf_addr    = cur_q;
    assign dump_valid = valid_q;
    assign dump_addr  = daddr_q;
    assign dump_data  = ddata_q;
    assign dump_last  = dlast_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
